strand_scheduler: RTL and testbench

// - Frame sequencer and shared-memory arbiter for NUM_STRANDS strand_driver instances.
// - On each frame_tick: pulses start_frame to every enabled driver, then waits for all of them to finish.
// - Time-multiplexes one frame-buffer read port across the drivers: per-strand address = base + current_idx.
// - Sits between the frame buffer RAM and the strand_driver array, below the host config registers.

---
 rtl/strand_scheduler_pkg.sv | 22 ++
 rtl/strand_mem_arbiter.sv | 66 ++++++
 rtl/strand_scheduler.sv | 126 ++++++++++++
 tb/tb_strand_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/strand_scheduler_pkg.sv
// Shared definitions for the strand frame scheduler: default widths, FSM state
// encoding and a saturating counter helper.
package strand_scheduler_pkg;

    localparam int DEF_NUM_STRANDS        = 8;
    localparam int DEF_MEM_DATA_WIDTH     = 24;
    localparam int DEF_MEM_ADDR_WIDTH     = 12;
    localparam int DEF_STRAND_PARAM_WIDTH = 16;
    localparam int DEF_WATCHDOG_CYCLES    = 2000000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } sched_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/strand_mem_arbiter.sv
// Round-robin time-multiplexer of one frame-buffer read port across all strands,
// with a registered pixel word held per strand.
module strand_mem_arbiter
    import strand_scheduler_pkg::*;
#(
    parameter int NUM_STRANDS        = DEF_NUM_STRANDS,
    parameter int MEM_DATA_WIDTH     = DEF_MEM_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH     = DEF_MEM_ADDR_WIDTH,
    parameter int STRAND_PARAM_WIDTH = DEF_STRAND_PARAM_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_STRANDS*MEM_ADDR_WIDTH-1:0]     strand_base,
    input  logic [NUM_STRANDS*STRAND_PARAM_WIDTH-1:0] drv_idx,
    output logic [NUM_STRANDS*MEM_DATA_WIDTH-1:0]     drv_mem_data,
    output logic                                     mem_rd,
    output logic [MEM_ADDR_WIDTH-1:0]                mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0]                mem_rdata
);

    localparam int RR_W = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1;
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(NUM_STRANDS - 1);

    logic [RR_W-1:0]               rr;
    logic [RR_W-1:0]               addr_tag;
    logic [RR_W-1:0]               data_tag;
    logic                          data_vld;
    logic [MEM_ADDR_WIDTH-1:0]     sel_base;
    logic [STRAND_PARAM_WIDTH-1:0] sel_idx;
    logic [MEM_ADDR_WIDTH-1:0]     next_addr;

    // Upper index bits are dropped and the sum wraps within the address space.
    always_comb begin
        sel_base  = strand_base[int'(rr)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        sel_idx   = drv_idx[int'(rr)*STRAND_PARAM_WIDTH +: STRAND_PARAM_WIDTH];
        next_addr = sel_base + MEM_ADDR_WIDTH'(sel_idx);
    end

    // Pipeline: issue address (tag follows), RAM answers next cycle, then store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= '0;
            addr_tag <= '0;
            data_tag <= '0;
            data_vld <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else begin
            rr       <= (rr == RR_LAST) ? '0 : rr + RR_W'(1);
            mem_rd   <= 1'b1;
            mem_addr <= next_addr;
            addr_tag <= rr;
            data_vld <= mem_rd;
            data_tag <= addr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_mem_data <= '0;
        end else if (data_vld) begin
            drv_mem_data[int'(data_tag)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_rdata;
        end
    end

endmodule

// File: rtl/strand_scheduler.sv
// Frame sequencer for the strand driver array: starts enabled drivers on each
// frame tick, waits for their done pulses under a watchdog, and counts dropped ticks.
module strand_scheduler
    import strand_scheduler_pkg::*;
#(
    parameter int NUM_STRANDS        = DEF_NUM_STRANDS,
    parameter int MEM_DATA_WIDTH     = DEF_MEM_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH     = DEF_MEM_ADDR_WIDTH,
    parameter int STRAND_PARAM_WIDTH = DEF_STRAND_PARAM_WIDTH,
    parameter int WATCHDOG_CYCLES    = DEF_WATCHDOG_CYCLES
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     frame_tick,
    input  logic [NUM_STRANDS-1:0]                   strand_enable,
    input  logic [NUM_STRANDS*MEM_ADDR_WIDTH-1:0]     strand_base,
    input  logic [NUM_STRANDS*STRAND_PARAM_WIDTH-1:0] drv_idx,
    input  logic [NUM_STRANDS-1:0]                   drv_done,
    output logic [NUM_STRANDS-1:0]                   drv_start,
    output logic [NUM_STRANDS*MEM_DATA_WIDTH-1:0]     drv_mem_data,
    output logic                                     mem_rd,
    output logic [MEM_ADDR_WIDTH-1:0]                mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0]                mem_rdata,
    output logic                                     frame_active,
    output logic                                     frame_done,
    output logic                                     frame_timeout,
    output logic [7:0]                               overrun_count,
    output sched_state_e                             dbg_state
);

    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    sched_state_e           state;
    sched_state_e           state_nxt;
    logic [NUM_STRANDS-1:0] active_mask;
    logic [NUM_STRANDS-1:0] done_seen;
    logic [NUM_STRANDS-1:0] done_merged;
    logic                   all_done;
    logic                   wd_expired;
    logic                   frame_go;
    logic [WD_W-1:0]        wdog;

    assign done_merged = (done_seen | drv_done) & active_mask;
    assign all_done    = (done_merged == active_mask);
    assign wd_expired  = (wdog == WD_LAST);
    assign frame_go    = frame_tick && (strand_enable != '0);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        drv_start    = '0;
        frame_active = 1'b0;
        frame_done   = 1'b0;
        case (state)
            S_IDLE:   if (frame_go) state_nxt = S_START;
            S_START: begin
                drv_start    = active_mask;
                frame_active = 1'b1;
                state_nxt    = S_RUN;
            end
            S_RUN: begin
                frame_active = 1'b1;
                if (all_done || wd_expired) state_nxt = S_FINISH;
            end
            S_FINISH: begin
                frame_active = 1'b1;
                frame_done   = 1'b1;
                state_nxt    = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Completion has priority over a simultaneous watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_mask   <= '0;
            done_seen     <= '0;
            wdog          <= '0;
            frame_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (frame_go) active_mask <= strand_enable;
                S_START: begin
                    done_seen     <= '0;
                    wdog          <= '0;
                    frame_timeout <= 1'b0;
                end
                S_RUN: begin
                    done_seen <= done_merged;
                    if (!wd_expired) wdog <= wdog + WD_W'(1);
                    if (wd_expired && !all_done) frame_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              overrun_count <= 8'd0;
        else if (frame_tick && state != S_IDLE)  overrun_count <= sat_inc8(overrun_count);
    end

    strand_mem_arbiter #(
        .NUM_STRANDS        (NUM_STRANDS),
        .MEM_DATA_WIDTH     (MEM_DATA_WIDTH),
        .MEM_ADDR_WIDTH     (MEM_ADDR_WIDTH),
        .STRAND_PARAM_WIDTH (STRAND_PARAM_WIDTH)
    ) u_arbiter (
        .clk          (clk),
        .rst_n        (rst_n),
        .strand_base  (strand_base),
        .drv_idx      (drv_idx),
        .drv_mem_data (drv_mem_data),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata)
    );

endmodule

// File: tb/tb_strand_scheduler.sv
// Directed bench for strand_scheduler: frame sequencing, overrun, watchdog and
// arbiter data checked against a frame-level reference model every cycle.
`timescale 1ns/1ps
module tb_strand_scheduler;
    import strand_scheduler_pkg::*;

    localparam int N  = 8;
    localparam int DW = 24;
    localparam int AW = 12;
    localparam int PW = 16;
    localparam int WD = 100;

    // valid/ready: no handshakes here; frame_tick and drv_done are single-cycle
    // strobes sampled on the rising edge, driven 1 ns after it.
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_tick = 1'b0;
    logic [N-1:0]    strand_enable = '0;
    logic [N*AW-1:0] strand_base = '0;
    logic [N*PW-1:0] drv_idx = '0;
    logic [N-1:0]    drv_done = '0;
    logic [N-1:0]    drv_start;
    logic [N*DW-1:0] drv_mem_data;
    logic            mem_rd;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata = '0;
    logic            frame_active;
    logic            frame_done;
    logic            frame_timeout;
    logic [7:0]      overrun_count;
    sched_state_e    dbg_state;

    strand_scheduler #(
        .NUM_STRANDS(N), .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW),
        .STRAND_PARAM_WIDTH(PW), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .strand_enable(strand_enable), .strand_base(strand_base),
        .drv_idx(drv_idx), .drv_done(drv_done), .drv_start(drv_start),
        .drv_mem_data(drv_mem_data), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .frame_active(frame_active),
        .frame_done(frame_done), .frame_timeout(frame_timeout),
        .overrun_count(overrun_count), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // frame-buffer RAM: mem[a] = a, one-cycle read latency
    always_ff @(posedge clk) if (mem_rd) mem_rdata <= DW'(mem_addr);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: frame phases 0 idle, 1 start, 2 run, 3 finish
    int           m_ph = 0;
    logic [N-1:0] m_mask = '0;
    logic [N-1:0] m_seen = '0;
    int           m_run_cycles = 0;
    logic         m_to = 1'b0;
    int           m_ovr = 0;
    logic         m_live = 1'b0;
    int           m_stable[N];
    logic [AW-1:0] m_addr[N];
    logic [0:0]   exp_q[$];

    initial begin
        for (int i = 0; i < N; i++) begin m_stable[i] = 0; m_addr[i] = '0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = 0; m_mask = '0; m_seen = '0; m_run_cycles = 0;
                m_to = 1'b0; m_ovr = 0; m_live = 1'b0;
                for (int i = 0; i < N; i++) m_stable[i] = 0;
                exp_q.delete();
            end else begin
                m_live = 1'b1;
                if (frame_tick && m_ph != 0 && m_ovr < 255) m_ovr = m_ovr + 1;
                case (m_ph)
                    0: if (frame_tick && strand_enable != '0) begin m_mask = strand_enable; m_ph = 1; end
                    1: begin m_seen = '0; m_run_cycles = 0; m_to = 1'b0; m_ph = 2; end
                    2: begin
                        m_seen = (m_seen | drv_done) & m_mask;
                        m_run_cycles = m_run_cycles + 1;
                        if (m_seen == m_mask) m_ph = 3;
                        else if (m_run_cycles == WD) begin m_to = 1'b1; m_ph = 3; end
                        if (m_ph == 3) exp_q.push_back(m_to);
                    end
                    default: m_ph = 0;
                endcase
                for (int i = 0; i < N; i++) begin
                    logic [AW-1:0] a;
                    a = strand_base[i*AW +: AW] + drv_idx[i*PW +: AW];
                    if (a != m_addr[i]) begin m_addr[i] = a; m_stable[i] = 1; end
                    else if (m_stable[i] < 1000) m_stable[i] = m_stable[i] + 1;
                end
            end
        end
    end

    // scoreboard: every cycle on the falling edge
    initial forever begin
        @(negedge clk);
        chk("drv_start", drv_start, (m_ph == 1) ? m_mask : '0);
        chk("frame_active", frame_active, m_ph != 0);
        chk("frame_done", frame_done, m_ph == 3);
        chk("frame_timeout", frame_timeout, m_to);
        chk("overrun_count", overrun_count, m_ovr);
        chk("mem_rd", mem_rd, m_live);
        for (int i = 0; i < N; i++)
            if (m_stable[i] >= N + 2)
                chk($sformatf("drv_mem_data[%0d]", i), drv_mem_data[i*DW +: DW], m_addr[i]);
        if (frame_done) begin
            chk("frame_q_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) chk("frame_outcome", frame_timeout, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    endtask

    task automatic wait_state(input sched_state_e s, input int budget);
        int n = 0;
        while (dbg_state != s && n < budget) begin step(1); n++; end
        if (dbg_state != s) chk("wait_state", dbg_state, s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; frame_tick = 1'b0; drv_done = '0;
        step(2);
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_active", frame_active, 0);
        chk("rst_ovr", overrun_count, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_data", drv_mem_data, 0);
        @(negedge clk); rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        int cnt;
        // 1: basic frame with staggered done pulses
        do_reset();
        strand_enable = 8'h0F;
        pulse_tick();
        chk("t1_start", drv_start, 8'h0F);
        step(1);
        chk("t1_start_once", drv_start, 8'h00);
        drv_done = 8'h01; step(1); drv_done = 8'h00; step(2);
        drv_done = 8'h04; step(1); drv_done = 8'h02; step(1); drv_done = 8'h00; step(3);
        drv_done = 8'h08; step(1); drv_done = 8'h00;
        chk("t1_done", frame_done, 1);
        step(1);
        chk("t1_idle", frame_active, 0);

        // 2: ignored idle tick, overrun counting and saturation
        do_reset();
        strand_enable = 8'h00;
        pulse_tick();
        chk("t2_no_start", drv_start, 0);
        chk("t2_no_active", frame_active, 0);
        chk("t2_ovr0", overrun_count, 0);
        strand_enable = 8'hFF;
        pulse_tick();
        frame_tick = 1'b1; step(3); frame_tick = 1'b0;
        chk("t2_ovr3", overrun_count, 3);
        drv_done = 8'hFF; step(1); drv_done = 8'h00;
        wait_state(S_IDLE, 5);
        frame_tick = 1'b1; step(300); frame_tick = 1'b0;
        chk("t2_ovr_sat", overrun_count, 255);
        drv_done = 8'hFF; wait_state(S_IDLE, 200); drv_done = 8'h00;

        // 3: watchdog abort, then next START clears frame_timeout
        do_reset();
        strand_enable = 8'h07;
        pulse_tick();
        wait_state(S_RUN, 5);
        drv_done = 8'h03; step(1); drv_done = 8'h00;
        cnt = 1;
        while (frame_done !== 1'b1 && cnt < 300) begin step(1); cnt++; end
        chk("t3_wd_latency", cnt, WD);
        chk("t3_timeout", frame_timeout, 1);
        step(2);
        chk("t3_sticky", frame_timeout, 1);
        pulse_tick(); step(1);
        chk("t3_cleared", frame_timeout, 0);
        drv_done = 8'h07; step(1); drv_done = 8'h00; step(2);

        // 4: arbiter addressing and wrap
        do_reset();
        for (int i = 0; i < N; i++) begin
            strand_base[i*AW +: AW] = AW'(i * 160);
            drv_idx[i*PW +: PW] = PW'(i);
        end
        step(N + 3);
        for (int i = 0; i < N; i++)
            chk($sformatf("t4_data%0d", i), drv_mem_data[i*DW +: DW], i * 161);
        strand_base[0 +: AW] = 12'hFFF; drv_idx[0 +: PW] = 16'h0002;
        strand_base[AW +: AW] = 12'h000; drv_idx[PW +: PW] = 16'hF005;
        step(N + 3);
        chk("t4_wrap", drv_mem_data[0 +: DW], 1);
        chk("t4_trunc", drv_mem_data[DW +: DW], 5);

        // 5: done on inactive strand ignored; done and expiry together
        do_reset();
        strand_enable = 8'h01;
        pulse_tick();
        wait_state(S_RUN, 5);
        drv_done = 8'h20; step(1); drv_done = 8'h00; step(3);
        chk("t5_inactive_done", frame_active, 1);
        drv_done = 8'h01; step(1); drv_done = 8'h00;
        chk("t5_done", frame_done, 1);
        step(2);
        pulse_tick();
        wait_state(S_RUN, 5);
        step(WD - 1);
        drv_done = 8'h01; step(1); drv_done = 8'h00;
        chk("t5_tie_done", frame_done, 1);
        chk("t5_tie_timeout", frame_timeout, 0);
        step(2);

        // 6: asynchronous reset in the middle of a frame
        for (int i = 0; i < N; i++) begin
            strand_base[i*AW +: AW] = AW'(i * 16 + 1);
            drv_idx[i*PW +: PW] = '0;
        end
        strand_enable = 8'hFF;
        step(N + 3);
        pulse_tick();
        wait_state(S_RUN, 5);
        frame_tick = 1'b1; step(2); frame_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_state", dbg_state, S_IDLE);
        chk("t6_active", frame_active, 0);
        chk("t6_ovr", overrun_count, 0);
        chk("t6_mem_rd", mem_rd, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_data", drv_mem_data, 0);
        @(negedge clk); rst_n = 1'b1;
        step(N + 4);

        if (exp_q.size() != 0) chk("exp_q_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
